// File: rtl/day_night_pkg.sv
// Shared types and defaults for the day/night fade sequencer.
// Milestone targets are 15 bits so that saturation stays out of score range.
package day_night_pkg;

  typedef enum logic [1:0] {
    ST_DAY        = 2'd0,
    ST_FADE_DARK  = 2'd1,
    ST_NIGHT      = 2'd2,
    ST_FADE_LIGHT = 2'd3
  } state_t;

  localparam int PERIOD_DEF    = 700;
  localparam int DARK_LEN_DEF  = 200;
  localparam int LEVEL_MAX_DEF = 15;

  localparam logic [14:0] TGT_SAT = 15'h7FFF;

  function automatic logic [14:0] sat_add(
    input logic [14:0] a,
    input logic [14:0] b
  );
    logic [15:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15] ? TGT_SAT : s[14:0];
  endfunction

endpackage

// File: rtl/day_night_ctrl_tick.sv
// Fade prescaler: one-cycle tick every DIV enabled cycles.
// clr and rst both return the count to zero; en freezes it.
module fade_tick_gen #(
  parameter int DIV = 8388608
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = en & w_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/day_night_ctrl.sv
// Day/night sequencer: score milestones drive a registered fade level
// for the colour-inversion datapath.
module day_night_ctrl
  import day_night_pkg::*;
#(
  parameter int PERIOD    = PERIOD_DEF,
  parameter int DARK_LEN  = DARK_LEN_DEF,
  parameter int FADE_DIV  = 8388608,
  parameter int LEVEL_MAX = LEVEL_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] game_score,
  input  logic        pause,
  output logic [3:0]  fade_level,
  output logic        night,
  output logic        busy
);

  localparam logic [14:0] P15  = 15'(PERIOD);
  localparam logic [14:0] D15  = 15'(DARK_LEN);
  localparam logic [3:0]  LMAX = 4'(LEVEL_MAX);
  localparam logic [3:0]  LM1  = 4'(LEVEL_MAX - 1);

  state_t      r_state, w_state_n;
  logic [3:0]  r_level, w_level_n;
  logic [14:0] r_next_dark, w_next_dark_n;
  logic [14:0] r_light_at, w_light_at_n;
  logic        r_night, r_busy;

  logic        w_clr, w_tick;
  logic [14:0] w_score;
  logic        w_dark_hit, w_light_hit;

  assign w_clr       = (game_score == 14'd0);
  assign w_score     = {1'b0, game_score};
  assign w_dark_hit  = (w_score >= r_next_dark);
  assign w_light_hit = (w_score >= r_light_at);

  fade_tick_gen #(
    .DIV (FADE_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (~pause),
    .tick (w_tick)
  );

  always_comb begin
    w_state_n     = r_state;
    w_level_n     = r_level;
    w_next_dark_n = r_next_dark;
    w_light_at_n  = r_light_at;
    if (w_clr) begin
      w_state_n     = ST_DAY;
      w_level_n     = 4'd0;
      w_next_dark_n = P15;
      w_light_at_n  = 15'd0;
    end else if (!pause) begin
      unique case (r_state)
        ST_DAY, ST_FADE_LIGHT: begin
          if (w_dark_hit) begin
            w_state_n     = ST_FADE_DARK;
            w_light_at_n  = sat_add(r_next_dark, D15);
            w_next_dark_n = sat_add(r_next_dark, P15);
          end else if (r_state == ST_FADE_LIGHT && w_tick) begin
            // Level can be 0 here if light came before the first step.
            if (r_level <= 4'd1) begin
              w_level_n = 4'd0;
              w_state_n = ST_DAY;
            end else begin
              w_level_n = r_level - 1'b1;
            end
          end
        end
        ST_FADE_DARK, ST_NIGHT: begin
          if (w_light_hit) begin
            w_state_n = ST_FADE_LIGHT;
          end else if (r_state == ST_FADE_DARK && w_tick) begin
            if (r_level >= LM1) begin
              w_level_n = LMAX;
              w_state_n = ST_NIGHT;
            end else begin
              w_level_n = r_level + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_DAY;
      r_level     <= 4'd0;
      r_next_dark <= P15;
      r_light_at  <= 15'd0;
      r_night     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_level     <= w_level_n;
      r_next_dark <= w_next_dark_n;
      r_light_at  <= w_light_at_n;
      r_night     <= (w_state_n == ST_FADE_DARK) ||
                     (w_state_n == ST_NIGHT);
      r_busy      <= (w_state_n == ST_FADE_DARK) ||
                     (w_state_n == ST_FADE_LIGHT);
    end
  end

  assign fade_level = r_level;
  assign night      = r_night;
  assign busy       = r_busy;

endmodule

// File: tb/tb_day_night_ctrl.sv
// Bench for day_night_ctrl: vector table, corner sequences and a
// randomized run against a score-rule reference model.
module tb_day_night_ctrl;

  localparam int DIV  = 4;
  localparam int PER  = 700;
  localparam int DLEN = 200;
  localparam int LMAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] score = 14'd0;
  logic        pause = 1'b0;
  logic [3:0]  fade_level;
  logic        night, busy;

  int n_chk  = 0;
  int n_fail = 0;

  // model: phase 0 day, 1 darkening, 2 night, 3 lightening
  int m_ph, m_lvl, m_nd, m_la, m_pre;

  always #5 clk = ~clk;

  day_night_ctrl #(
    .PERIOD    (PER),
    .DARK_LEN  (DLEN),
    .FADE_DIV  (DIV),
    .LEVEL_MAX (LMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .game_score (score),
    .pause      (pause),
    .fade_level (fade_level),
    .night      (night),
    .busy       (busy)
  );

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    bit tick, fired;
    if (rst || score == 0) begin
      m_ph = 0; m_lvl = 0; m_nd = PER; m_la = 0; m_pre = 0;
    end else if (!pause) begin
      tick  = (m_pre == DIV - 1);
      m_pre = tick ? 0 : m_pre + 1;
      fired = 0;
      if ((m_ph == 0 || m_ph == 3) && int'(score) >= m_nd) begin
        m_ph  = 1;
        m_la  = imin(m_nd + DLEN, 32767);
        m_nd  = imin(m_nd + PER, 32767);
        fired = 1;
      end else if ((m_ph == 1 || m_ph == 2) && int'(score) >= m_la) begin
        m_ph  = 3;
        fired = 1;
      end
      if (!fired && tick) begin
        if (m_ph == 1) begin
          m_lvl = imin(m_lvl + 1, LMAX);
          if (m_lvl == LMAX) m_ph = 2;
        end else if (m_ph == 3) begin
          m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
          if (m_lvl == 0) m_ph = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    logic en, eb;
    @(posedge clk);
    model_step();
    #1;
    en = (m_ph == 1 || m_ph == 2);
    eb = (m_ph == 1 || m_ph == 3);
    n_chk++;
    if (fade_level !== 4'(m_lvl) || night !== en || busy !== eb) begin
      n_fail++;
      $display("FAIL model t=%0t got lvl=%0d n=%b b=%b want lvl=%0d n=%b b=%b",
               $time, fade_level, night, busy, m_lvl, en, eb);
    end
  endtask

  task automatic chk(string nm, int lvl, logic nt, logic bz);
    n_chk++;
    if (fade_level !== 4'(lvl) || night !== nt || busy !== bz) begin
      n_fail++;
      $display("FAIL %s got lvl=%0d n=%b b=%b want lvl=%0d n=%b b=%b",
               nm, fade_level, night, busy, lvl, nt, bz);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; score = 14'd0; pause = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    int   sc;
    logic pz;
    int   n;
    int   lvl;
    logic nt;
    logic bz;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int s;
    tbl.push_back('{700,  1'b0, 1,  0,  1'b1, 1'b1});
    tbl.push_back('{700,  1'b0, 3,  1,  1'b1, 1'b1});
    tbl.push_back('{700,  1'b0, 4,  2,  1'b1, 1'b1});
    tbl.push_back('{700,  1'b0, 52, 15, 1'b1, 1'b0});
    tbl.push_back('{700,  1'b0, 10, 15, 1'b1, 1'b0});
    tbl.push_back('{900,  1'b0, 1,  15, 1'b0, 1'b1});
    tbl.push_back('{900,  1'b0, 1,  14, 1'b0, 1'b1});
    tbl.push_back('{900,  1'b0, 28, 7,  1'b0, 1'b1});
    tbl.push_back('{900,  1'b0, 4,  6,  1'b0, 1'b1});
    tbl.push_back('{1400, 1'b0, 1,  6,  1'b1, 1'b1});
    tbl.push_back('{1400, 1'b0, 3,  7,  1'b1, 1'b1});
    tbl.push_back('{1400, 1'b0, 32, 15, 1'b1, 1'b0});
    tbl.push_back('{1599, 1'b0, 5,  15, 1'b1, 1'b0});
    tbl.push_back('{1600, 1'b0, 1,  15, 1'b0, 1'b1});
    tbl.push_back('{2099, 1'b0, 3,  14, 1'b0, 1'b1});
    tbl.push_back('{2100, 1'b0, 1,  14, 1'b1, 1'b1});
    tbl.push_back('{2299, 1'b0, 2,  15, 1'b1, 1'b0});
    tbl.push_back('{2300, 1'b0, 1,  15, 1'b0, 1'b1});

    // nominal cycle, reversal, light/dark target spacing
    do_reset();
    chk("reset", 0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      score = 14'(tbl[i].sc);
      pause = tbl[i].pz;
      repeat (tbl[i].n) cyc();
      chk($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].nt, tbl[i].bz);
    end

    // zero score clears mid-fade, even while paused
    do_reset();
    score = 14'd700;
    repeat (36) cyc();
    chk("zr_lvl9", 9, 1'b1, 1'b1);
    pause = 1'b1;
    repeat (3) cyc();
    chk("zr_hold", 9, 1'b1, 1'b1);
    score = 14'd0;
    cyc();
    chk("zr_clear", 0, 1'b0, 1'b0);
    score = 14'd700; pause = 1'b0;
    cyc();
    chk("zr_retrig", 0, 1'b1, 1'b1);

    // early light before full night
    repeat (11) cyc();
    chk("el_lvl3", 3, 1'b1, 1'b1);
    score = 14'd900;
    cyc();
    chk("el_enter", 3, 1'b0, 1'b1);
    repeat (3) cyc();
    chk("el_step", 2, 1'b0, 1'b1);
    repeat (17) cyc();
    chk("el_day", 0, 1'b0, 1'b0);

    // skipped milestone
    do_reset();
    score = 14'd650;
    repeat (5) cyc();
    chk("sk_day", 0, 1'b0, 1'b0);
    score = 14'd1450;
    cyc(); chk("sk_dark", 0, 1'b1, 1'b1);
    cyc(); chk("sk_light", 0, 1'b0, 1'b1);
    cyc(); chk("sk_redark", 0, 1'b1, 1'b1);
    cyc(); chk("sk_stay", 0, 1'b1, 1'b1);

    // top of score range: targets run past 16383 and stop firing
    do_reset();
    score = 14'd16000;
    repeat (60) cyc();
    score = 14'd16383;
    repeat (100) cyc();
    chk("top_idle", 0, 1'b0, 1'b0);

    // pause freezes level, state and prescaler
    do_reset();
    score = 14'd700;
    repeat (6) cyc();
    chk("pz_pre", 1, 1'b1, 1'b1);
    pause = 1'b1; score = 14'd900;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("pz_frozen", 1, 1'b1, 1'b1);
    end
    score = 14'd700;
    cyc();
    pause = 1'b0;
    cyc(); chk("pz_rel1", 1, 1'b1, 1'b1);
    cyc(); chk("pz_rel2", 2, 1'b1, 1'b1);

    // randomized run against the model
    do_reset();
    s = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rst = (r < 1);
      if (r < 3) s = 0;
      else if (r < 70) s = s + int'($urandom_range(0, 30));
      else if (r < 72) s = int'($urandom_range(1, 16383));
      else if (r < 74) s = s - int'($urandom_range(0, 300));
      if (s < 0) s = 1;
      if (s > 16383) s = 16383;
      score = 14'(s);
      pause = ($urandom_range(0, 9) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
